ila_sample_unpack: RTL and testbench
====================================

// Module: ila_sample_unpack
// PURPOSE
//  Receiving end of the ILA DMA sample stream. Accepts DATA_W-wide words on an AXI-Stream-style slave.
//  Reassembles each group of N_PARTS words into one full sample; words arrive part 0 first, least-significant part first.
//  Splits off the optional clock-counter field and presents whole samples on a valid/ready output through a small FIFO.
//  Used to replay or check captured buffers inside the SoC and in the verification harness.
// PARAMETERS
//  DATA_W        32  stream word width
//  SIGNAL_W      40  sampled signal width (excluding clock counter)
//  CLK_COUNTER   0   1: each sample carries a CLK_COUNTER_W counter in its LSBs
//  CLK_COUNTER_W 16  clock counter width
//  BUFFER_W      10  sample-count width (expected/received counters)
//  FIFO_W        2   log2 of sample FIFO depth (depth 4)
//  Derived:
//   I_SIGNAL_W = SIGNAL_W + (CLK_COUNTER ? CLK_COUNTER_W : 0)
//   N_PARTS = CEIL_DIV(I_SIGNAL_W, DATA_W)
// PORTS
//  clk_i           in   1              system clock
//  cke_i           in   1              clock enable; 0 freezes all state
//  rst_i           in   1              synchronous active-high reset
//  start_i         in   1              begin reception (honoured in IDLE or DONE)
//  abort_i         in   1              abandon transfer, flush FIFO, go IDLE
//  n_samples_i     in   BUFFER_W       samples to receive, sampled on start_i
//  s_tdata_i       in   DATA_W         stream word
//  s_tvalid_i      in   1              stream word valid
//  s_tready_o      out  1              stream word accepted when tvalid & tready
//  sample_o        out  SIGNAL_W       reassembled signal field (FIFO head)
//  clk_count_o     out  CLK_COUNTER_W  counter field of FIFO head (0 if CLK_COUNTER=0)
//  sample_valid_o  out  1              FIFO not empty
//  sample_ready_i  in   1              pop FIFO head when valid & ready
//  received_o      out  BUFFER_W       whole samples pushed since start
//  busy_o          out  1              state RECV or DRAIN
//  done_o          out  1              state DONE
// BEHAVIOUR
//  Reset values:
//   - outputs 0, state IDLE, part index 0, FIFO empty, counters 0.
//  State machine:
//   - IDLE: start_i loads expected=n_samples_i and clears received/part index.
//     If n_samples_i==0, go to DONE; otherwise go to RECV.
//   - RECV: s_tready_o = (part_idx!=N_PARTS-1) | !fifo_full.
//     On handshake with part_idx<N_PARTS-1: word is stored in assembly slot part_idx and part_idx increments.
//     On handshake with part_idx==N_PARTS-1: {word, slots} is truncated to I_SIGNAL_W and pushed to the FIFO in the same cycle.
//     On that last-part handshake, part_idx returns to 0 and received increments.
//     Pad bits above I_SIGNAL_W are ignored.
//     When received reaches expected (counted on the push cycle), go to DRAIN.
//   - DRAIN: s_tready_o=0; when the FIFO is empty, go to DONE.
//   - DONE: done_o=1; holds until start_i (re-arm as from IDLE) or abort_i.
//  abort_i (any state, priority over start_i):
//   - next cycle state is IDLE, FIFO is empty, part_idx=0; received holds its value.
//  s_tready_o is 0 in IDLE, DRAIN and DONE. It is combinational from state/part_idx/fifo_full and never depends on s_tvalid_i.
//  Latency: last-part handshake in cycle t -> sample_valid_o=1 in cycle t+1 (FIFO is first-word fall-through).
//  Full FIFO: the last part is stalled (tready=0) and earlier parts are still accepted. A pop in the same cycle does not open tready; this keeps the timing path short.
//  Simultaneous push and pop when the FIFO is non-empty: both occur and the count is unchanged.
//  received_o saturates at 2^BUFFER_W-1. expected=2^BUFFER_W-1 is legal.
//  N_PARTS==1: every handshake is a last-part handshake.
//  Field split: clk_count_o = head[CLK_COUNTER_W-1:0]; sample_o = head[I_SIGNAL_W-1 -: SIGNAL_W].
//  rst_i overrides everything, including mid-sample; partial assembly is discarded.
// STRUCTURE
//  Shared header (iob_ila_lib.vh / iob_ila_conf.vh): CEIL_DIV macro and the 2-bit state encodings
//   IOB_ILA_UNPK_IDLE=0, RECV=1, DRAIN=2, DONE=3.
//  Sub-module ila_sample_fifo (DATA_W=I_SIGNAL_W, ADDR_W=FIFO_W): register-based FWFT FIFO, sync reset, flush input, full/empty outputs.
//  The top contains the FSM, part index, assembly slots (N_PARTS-1 words) and counters.
// TESTING (DATA_W=32, SIGNAL_W=40, CLK_COUNTER=0 unless noted; N_PARTS=2)
//  1. start n=1; words 0x11223344, 0x000000AB
//     -> sample_o=0xAB11223344 one cycle after 2nd handshake; DONE after pop; received_o=1.
//  2. start n=6; tvalid always high; sample_ready_i=0 until 4 samples queued
//     -> tready low on part 1 of sample 5, parts 0 still accepted; release ready -> all 6 in order; DONE.
//  3. start n=3; abort after first word of sample 2
//     -> next cycle IDLE, sample_valid_o=0, tready=0; restart n=1 reassembles cleanly from part 0.
//  4. start n=0 -> DONE next cycle, tready never asserted.
//  5. CLK_COUNTER=1, CLK_COUNTER_W=16 (I_SIGNAL_W=56); words 0xDEAD0007, 0x00BEEF01
//     -> clk_count_o=0x0007, sample_o=0xBEEF01DEAD.
//  6. rst_i asserted mid-sample and with cke_i=0 -> all outputs 0 next edge; cke_i=0 alone freezes state and FIFO.

Source files
------------

// File: rtl/ila_sample_unpack_pkg.sv
// ============================================================================
// Module   : ila_sample_unpack_pkg
// Brief    : Shared state encodings and sizing helper for the ILA sample unpacker
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ila_sample_unpack_pkg;

  typedef enum logic [1:0] {
    IOB_ILA_UNPK_IDLE  = 2'd0,
    IOB_ILA_UNPK_RECV  = 2'd1,
    IOB_ILA_UNPK_DRAIN = 2'd2,
    IOB_ILA_UNPK_DONE  = 2'd3
  } unpk_state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ila_sample_unpack_fifo.sv
// ============================================================================
// Module   : ila_sample_fifo
// Brief    : Register-based first-word-fall-through FIFO with flush and clock enable
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ila_sample_fifo #(
  parameter int DATA_W = 56,
  parameter int ADDR_W = 2
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              w_push;
  logic              w_pop;

  assign full_o  = r_count[ADDR_W];
  assign empty_o = (r_count == '0);
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  // Head reads as zero when empty so the unpacker's outputs are clean after reset/flush.
  assign data_o  = empty_o ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk_i) begin
    if (cke_i && w_push && !flush_i) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (cke_i) begin
      if (flush_i) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ila_sample_unpack.sv
// ============================================================================
// Module   : ila_sample_unpack
// Brief    : Reassembles multi-word ILA stream samples and queues them for readout
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ila_sample_unpack
  import ila_sample_unpack_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int SIGNAL_W      = 40,
  parameter int CLK_COUNTER   = 0,
  parameter int CLK_COUNTER_W = 16,
  parameter int BUFFER_W      = 10,
  parameter int FIFO_W        = 2
) (
  input  logic                     clk_i,
  input  logic                     cke_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic [BUFFER_W-1:0]      n_samples_i,
  input  logic [DATA_W-1:0]        s_tdata_i,
  input  logic                     s_tvalid_i,
  output logic                     s_tready_o,
  output logic [SIGNAL_W-1:0]      sample_o,
  output logic [CLK_COUNTER_W-1:0] clk_count_o,
  output logic                     sample_valid_o,
  input  logic                     sample_ready_i,
  output logic [BUFFER_W-1:0]      received_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int I_SIGNAL_W = SIGNAL_W + ((CLK_COUNTER != 0) ? CLK_COUNTER_W : 0);
  localparam int N_PARTS    = ceil_div(I_SIGNAL_W, DATA_W);
  localparam int PI_W       = (N_PARTS > 1) ? $clog2(N_PARTS) : 1;
  localparam logic [PI_W-1:0] c_last_part = PI_W'(N_PARTS - 1);

  unpk_state_t                r_state;
  unpk_state_t                w_state_nxt;
  logic [PI_W-1:0]            r_part_idx;
  logic [BUFFER_W-1:0]        r_expected;
  logic [BUFFER_W-1:0]        r_received;
  logic [BUFFER_W-1:0]        w_recv_inc;
  logic                       w_start_arm;
  logic                       w_last;
  logic                       w_hs;
  logic                       w_push;
  logic                       w_fifo_full;
  logic                       w_fifo_empty;
  logic [N_PARTS*DATA_W-1:0]  w_assembled;
  logic [I_SIGNAL_W-1:0]      w_head;

  assign w_last     = (r_part_idx == c_last_part);
  // Only the last part needs FIFO room; earlier parts land in assembly slots.
  assign s_tready_o = (r_state == IOB_ILA_UNPK_RECV) & (~w_last | ~w_fifo_full);
  assign w_hs       = s_tvalid_i & s_tready_o;
  assign w_push     = w_hs & w_last;
  assign w_recv_inc = (&r_received) ? r_received : r_received + 1'b1;

  generate
    if (N_PARTS > 1) begin : g_slots
      logic [(N_PARTS-1)*DATA_W-1:0] r_slots;
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_slots <= '0;
        end else if (cke_i && w_hs && !w_last) begin
          r_slots[int'(r_part_idx)*DATA_W +: DATA_W] <= s_tdata_i;
        end
      end
      assign w_assembled = {s_tdata_i, r_slots};
    end else begin : g_no_slots
      assign w_assembled = s_tdata_i;
    end

    if (N_PARTS*DATA_W > I_SIGNAL_W) begin : g_pad
      logic w_pad_unused;
      assign w_pad_unused = ^w_assembled[N_PARTS*DATA_W-1:I_SIGNAL_W];
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    w_start_arm = 1'b0;
    if (abort_i) begin
      w_state_nxt = IOB_ILA_UNPK_IDLE;
    end else begin
      case (r_state)
        IOB_ILA_UNPK_IDLE, IOB_ILA_UNPK_DONE: begin
          if (start_i) begin
            w_start_arm = 1'b1;
            if (n_samples_i == '0) w_state_nxt = IOB_ILA_UNPK_DONE;
            else                   w_state_nxt = IOB_ILA_UNPK_RECV;
          end
        end
        IOB_ILA_UNPK_RECV: begin
          if (w_push && (w_recv_inc == r_expected)) w_state_nxt = IOB_ILA_UNPK_DRAIN;
        end
        IOB_ILA_UNPK_DRAIN: begin
          if (w_fifo_empty) w_state_nxt = IOB_ILA_UNPK_DONE;
        end
        default: w_state_nxt = IOB_ILA_UNPK_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IOB_ILA_UNPK_IDLE;
    end else if (cke_i) begin
      r_state <= w_state_nxt;
    end
  end

  // Abort keeps the received count so software can see how far the transfer got.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_part_idx <= '0;
      r_expected <= '0;
      r_received <= '0;
    end else if (cke_i) begin
      if (abort_i) begin
        r_part_idx <= '0;
      end else if (w_start_arm) begin
        r_expected <= n_samples_i;
        r_received <= '0;
        r_part_idx <= '0;
      end else if (w_hs) begin
        if (w_last) begin
          r_part_idx <= '0;
          r_received <= w_recv_inc;
        end else begin
          r_part_idx <= r_part_idx + 1'b1;
        end
      end
    end
  end

  ila_sample_fifo #(
    .DATA_W (I_SIGNAL_W),
    .ADDR_W (FIFO_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .cke_i   (cke_i),
    .rst_i   (rst_i),
    .flush_i (abort_i),
    .push_i  (w_push),
    .data_i  (w_assembled[I_SIGNAL_W-1:0]),
    .pop_i   (sample_ready_i),
    .data_o  (w_head),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty)
  );

  assign sample_valid_o = ~w_fifo_empty;
  assign sample_o       = w_head[I_SIGNAL_W-1 -: SIGNAL_W];
  assign received_o     = r_received;
  assign busy_o         = (r_state == IOB_ILA_UNPK_RECV) | (r_state == IOB_ILA_UNPK_DRAIN);
  assign done_o         = (r_state == IOB_ILA_UNPK_DONE);

  generate
    if (CLK_COUNTER != 0) begin : g_clk_cnt
      assign clk_count_o = w_head[CLK_COUNTER_W-1:0];
    end else begin : g_no_clk_cnt
      assign clk_count_o = '0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_ila_sample_unpack.sv
// ============================================================================
// Module   : tb_ila_sample_unpack
// Brief    : Scoreboard bench for ila_sample_unpack (plain and clock-counter builds)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ila_sample_unpack;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cke;
  logic        start, abort;
  logic [9:0]  n_samples;
  logic [31:0] tdata;
  logic        tvalid, tready;
  logic [39:0] sample;
  logic [15:0] clk_count;
  logic        sample_valid, sample_ready;
  logic [9:0]  received;
  logic        busy, done;

  logic        k_start, k_abort;
  logic [9:0]  k_n;
  logic [31:0] k_tdata;
  logic        k_tvalid, k_tready;
  logic [39:0] k_sample;
  logic [15:0] k_clk;
  logic        k_valid, k_ready;
  logic [9:0]  k_received;
  logic        k_busy, k_done;

  ila_sample_unpack #(.DATA_W(32), .SIGNAL_W(40), .CLK_COUNTER(0), .CLK_COUNTER_W(16),
                      .BUFFER_W(10), .FIFO_W(2)) dut (
    .clk_i(clk), .cke_i(cke), .rst_i(rst), .start_i(start), .abort_i(abort),
    .n_samples_i(n_samples), .s_tdata_i(tdata), .s_tvalid_i(tvalid), .s_tready_o(tready),
    .sample_o(sample), .clk_count_o(clk_count), .sample_valid_o(sample_valid),
    .sample_ready_i(sample_ready), .received_o(received), .busy_o(busy), .done_o(done)
  );

  ila_sample_unpack #(.DATA_W(32), .SIGNAL_W(40), .CLK_COUNTER(1), .CLK_COUNTER_W(16),
                      .BUFFER_W(10), .FIFO_W(2)) dut_cc (
    .clk_i(clk), .cke_i(cke), .rst_i(rst), .start_i(k_start), .abort_i(k_abort),
    .n_samples_i(k_n), .s_tdata_i(k_tdata), .s_tvalid_i(k_tvalid), .s_tready_o(k_tready),
    .sample_o(k_sample), .clk_count_o(k_clk), .sample_valid_o(k_valid),
    .sample_ready_i(k_ready), .received_o(k_received), .busy_o(k_busy), .done_o(k_done)
  );

  int errors = 0;
  int checks = 0;
  logic [39:0] exp_q0[$];
  logic [55:0] exp_q1[$];
  logic [39:0] m0_exp;
  logic [55:0] m1_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Scoreboard monitors: pop whenever the DUT actually hands a sample over.
  always @(negedge clk) begin
    if (!rst && cke && sample_valid && sample_ready) begin
      if (exp_q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL mon0: unexpected sample %0h expected none", sample);
      end else begin
        m0_exp = exp_q0.pop_front();
        check("mon0 sample", sample, m0_exp);
        check("mon0 clk_count", clk_count, 16'h0);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && cke && k_valid && k_ready) begin
      if (exp_q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL mon1: unexpected sample %0h expected none", k_sample);
      end else begin
        m1_exp = exp_q1.pop_front();
        check("mon1 sample", k_sample, m1_exp[55:16]);
        check("mon1 clk_count", k_clk, m1_exp[15:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input bit which, input logic [31:0] w);
    bit ok = 1'b0;
    if (!which) begin tdata = w; tvalid = 1'b1; end
    else        begin k_tdata = w; k_tvalid = 1'b1; end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if ((!which && tready) || (which && k_tready)) begin ok = 1'b1; break; end
    end
    tick();
    if (!which) tvalid = 1'b0; else k_tvalid = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL send: word %0h accepted=0 required=1", w); end
  endtask

  task automatic pulse_start(input bit which, input logic [9:0] n);
    if (!which) begin start = 1'b1; n_samples = n; end
    else        begin k_start = 1'b1; k_n = n; end
    tick();
    start = 1'b0; k_start = 1'b0;
  endtask

  task automatic wait_done(input bit which, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ((!which && done) || (which && k_done)) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL %s: done=0 required=1", name); end
    tick();
  endtask

  logic [31:0] t2_w0 [6] = '{32'h01010101, 32'h02020202, 32'h03030303,
                             32'h04040404, 32'h05050505, 32'h06060606};
  logic [31:0] t2_w1 [6] = '{32'hFFFFFF10, 32'h12345620, 32'h00000030,
                             32'hABCDEF40, 32'h00000050, 32'h99999960};
  logic [39:0] t2_exp [6] = '{40'h1001010101, 40'h2002020202, 40'h3003030303,
                              40'h4004040404, 40'h5005050505, 40'h6006060606};

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cke = 1'b1; start = 1'b0; abort = 1'b0; n_samples = '0;
    tdata = '0; tvalid = 1'b1; sample_ready = 1'b0;
    k_start = 1'b0; k_abort = 1'b0; k_n = '0; k_tdata = '0; k_tvalid = 1'b0; k_ready = 1'b1;
    repeat (3) tick();
    check("reset valid", sample_valid, 0);
    check("reset sample", sample, 0);
    check("reset received", received, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset tready", tready, 0);
    check("reset cc done", k_done, 0);
    rst = 1'b0; tvalid = 1'b0;
    tick();

    // Test 1: single sample, latency and completion
    sample_ready = 1'b1;
    pulse_start(0, 10'd1);
    check("t1 busy", busy, 1);
    send(0, 32'h11223344);
    check("t1 valid after part0", sample_valid, 0);
    send(0, 32'h000000AB);
    exp_q0.push_back(40'hAB11223344);
    check("t1 valid latency", sample_valid, 1);
    check("t1 sample head", sample, 40'hAB11223344);
    wait_done(0, "t1 done");
    check("t1 received", received, 1);
    check("t1 busy end", busy, 0);

    // Test 2: FIFO fills, last part stalls, first part still accepted
    sample_ready = 1'b0;
    pulse_start(0, 10'd6);
    for (int k = 0; k < 4; k++) begin
      send(0, t2_w0[k]);
      send(0, t2_w1[k]);
      exp_q0.push_back(t2_exp[k]);
    end
    send(0, t2_w0[4]);
    tdata = t2_w1[4]; tvalid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t2 tready stall", tready, 0);
    end
    check("t2 received full", received, 4);
    check("t2 valid full", sample_valid, 1);
    tick();
    sample_ready = 1'b1;
    send(0, t2_w1[4]);
    exp_q0.push_back(t2_exp[4]);
    send(0, t2_w0[5]);
    send(0, t2_w1[5]);
    exp_q0.push_back(t2_exp[5]);
    wait_done(0, "t2 done");
    check("t2 received", received, 6);
    check("t2 queue drained", exp_q0.size(), 0);

    // Test 3: abort mid-sample, then clean restart
    sample_ready = 1'b0;
    pulse_start(0, 10'd3);
    send(0, 32'h01010101);
    send(0, 32'h00000010);
    exp_q0.push_back(40'h1001010101);
    send(0, 32'h02020202);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_q0.delete();
    tdata = 32'h55555555; tvalid = 1'b1;
    @(negedge clk);
    check("t3 busy", busy, 0);
    check("t3 done", done, 0);
    check("t3 valid", sample_valid, 0);
    check("t3 tready", tready, 0);
    check("t3 received hold", received, 1);
    tick();
    tvalid = 1'b0; sample_ready = 1'b1;
    pulse_start(0, 10'd1);
    send(0, 32'h11111111);
    send(0, 32'h000000CC);
    exp_q0.push_back(40'hCC11111111);
    wait_done(0, "t3 done restart");
    check("t3 received restart", received, 1);

    // Test 4: zero-length transfer from IDLE
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4 idle", done, 0);
    tvalid = 1'b1;
    pulse_start(0, 10'd0);
    check("t4 done", done, 1);
    check("t4 received", received, 0);
    repeat (2) begin
      @(negedge clk);
      check("t4 tready", tready, 0);
    end
    tick();
    tvalid = 1'b0;

    // Test 5: clock-counter build field split
    pulse_start(1, 10'd1);
    send(1, 32'hDEAD0007);
    send(1, 32'h00BEEF01);
    exp_q1.push_back(56'hBEEF01DEAD0007);
    wait_done(1, "t5 done");
    check("t5 received", k_received, 1);

    // Test 6: clock-enable freeze, then reset with cke low
    sample_ready = 1'b0;
    pulse_start(0, 10'd3);
    send(0, 32'h01010101);
    send(0, 32'h00000010);
    exp_q0.push_back(40'h1001010101);
    send(0, 32'h02020202);
    cke = 1'b0; sample_ready = 1'b1; tdata = 32'h00000020; tvalid = 1'b1;
    repeat (3) tick();
    check("t6 freeze received", received, 1);
    check("t6 freeze valid", sample_valid, 1);
    check("t6 freeze sample", sample, 40'h1001010101);
    check("t6 freeze busy", busy, 1);
    rst = 1'b1;
    tick();
    exp_q0.delete();
    check("t6 rst valid", sample_valid, 0);
    check("t6 rst sample", sample, 0);
    check("t6 rst received", received, 0);
    check("t6 rst busy", busy, 0);
    check("t6 rst tready", tready, 0);
    rst = 1'b0; cke = 1'b1; tvalid = 1'b0;
    tick();
    pulse_start(0, 10'd1);
    send(0, 32'h77777777);
    send(0, 32'h00000088);
    exp_q0.push_back(40'h8877777777);
    wait_done(0, "t6 done");
    check("t6 received", received, 1);

    check("final queue0 empty", exp_q0.size(), 0);
    check("final queue1 empty", exp_q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
